// File: rtl/m6502_alu_unit.sv
// m6502_alu_unit
//   Handshaked ALU for the M6502 core. It runs one AluOperation (ADC..LSR)
//   at a time at WIDTH bits. When the decimal flag is set, ADC and SBC get
//   an extra cycle for BCD correction.
//   Flow:    IDLE -> EXEC -> [DADJ] -> DONE -> IDLE.
//   Latency: o_valid is high two edges after the accept edge, or three
//            edges after it when BCD correction runs.
// Ports
//   clk, reset            core clock; synchronous active-high reset
//   i_valid / o_ready     request handshake (o_ready is high only in IDLE)
//   i_op                  operation: ADC=0 INC DEC SBC CMP AND OR EOR ASL ROL ROR LSR=11
//   i_a, i_b, i_carry     operands and carry in
//   i_decimal             status D bit at issue
//   o_valid / i_ready     result handshake (o_valid is high only in DONE)
//   o_result              WIDTH-bit result
//   o_flags               {N,V,Z,C}
//   o_flag_mask           {N,V,Z,C} write-back enables
module m6502_alu_unit #(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  input  logic             i_decimal,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags,
  output logic [3:0]       o_flag_mask
);
  localparam int MSB  = WIDTH - 1;
  localparam int NIBS = WIDTH / 4;

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_INC = 4'd1;
  localparam logic [3:0] OP_DEC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_CMP = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_EOR = 4'd7;
  localparam logic [3:0] OP_ASL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;
  localparam logic [3:0] OP_LSR = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DADJ, S_DONE} state_t;

  // BCD add, one nibble at a time from LSB to MSB. A nibble sum above 9
  // gets +6 and carries into the next nibble. Returns {carry, result}.
  function automatic logic [WIDTH:0] bcd_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin);
    logic [WIDTH-1:0] r;
    logic             cy;
    logic [4:0]       s;
    r  = {WIDTH{1'b0}};
    cy = cin;
    for (int i = 0; i < NIBS; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, cy};
      if (s > 5'd9) begin
        s  = s + 5'd6;
        cy = 1'b1;
      end else begin
        cy = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {cy, r};
  endfunction

  // BCD subtract, one nibble at a time with ripple borrow. A nibble that
  // borrows gets -6. The borrow into nibble 0 is the inverted carry in.
  function automatic logic [WIDTH-1:0] bcd_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin);
    logic [WIDTH-1:0] r;
    logic             bw;
    logic [4:0]       d;
    r  = {WIDTH{1'b0}};
    bw = ~cin;
    for (int i = 0; i < NIBS; i++) begin
      d  = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0000, bw};
      bw = d[4];
      if (bw) begin
        r[4*i +: 4] = d[3:0] - 4'd6;
      end else begin
        r[4*i +: 4] = d[3:0];
      end
    end
    return r;
  endfunction

  state_t           state, state_nxt;
  logic [3:0]       op_lat;
  logic [WIDTH-1:0] a_lat, b_lat;
  logic             carry_lat, dec_lat;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flags_q, mask_q;
  logic             accept, dec_path;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_n, alu_v, alu_z, alu_c;
  logic [3:0]       alu_mask;
  logic [WIDTH:0]   add_out;
  logic [WIDTH-1:0] adj_res;
  logic             adj_c;

  assign accept   = i_valid & o_ready;
  assign dec_path = DECIMAL_EN & dec_lat & ((op_lat == OP_ADC) | (op_lat == OP_SBC));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_EXEC; else state_nxt = S_IDLE;
      S_EXEC: if (dec_path) state_nxt = S_DADJ; else state_nxt = S_DONE;
      S_DADJ: state_nxt = S_DONE;
      S_DONE: if (o_valid & i_ready) state_nxt = S_IDLE; else state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the request on the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      op_lat    <= 4'd0;
      a_lat     <= {WIDTH{1'b0}};
      b_lat     <= {WIDTH{1'b0}};
      carry_lat <= 1'b0;
      dec_lat   <= 1'b0;
    end else if (accept) begin
      op_lat    <= i_op;
      a_lat     <= i_a;
      b_lat     <= i_b;
      carry_lat <= i_carry;
      dec_lat   <= i_decimal;
    end
  end

  // Binary ALU result and flags, computed from the captured operands
  always_comb begin
    sum      = {(WIDTH+1){1'b0}};
    alu_res  = a_lat;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_mask = 4'b0000;
    case (op_lat)
      OP_ADC: begin
        sum      = {1'b0, a_lat} + {1'b0, b_lat} + {{WIDTH{1'b0}}, carry_lat};
        alu_res  = sum[MSB:0];
        alu_c    = sum[WIDTH];
        alu_v    = (a_lat[MSB] == b_lat[MSB]) & (alu_res[MSB] != a_lat[MSB]);
        alu_mask = 4'b1111;
      end
      OP_SBC: begin
        sum      = {1'b0, a_lat} + {1'b0, ~b_lat} + {{WIDTH{1'b0}}, carry_lat};
        alu_res  = sum[MSB:0];
        alu_c    = sum[WIDTH];
        alu_v    = (a_lat[MSB] == ~b_lat[MSB]) & (alu_res[MSB] != a_lat[MSB]);
        alu_mask = 4'b1111;
      end
      OP_CMP: begin
        sum      = {1'b0, a_lat} + {1'b0, ~b_lat} + {{WIDTH{1'b0}}, 1'b1};
        alu_c    = sum[WIDTH];
        alu_mask = 4'b1011;
      end
      OP_INC: begin
        alu_res  = a_lat + {{(WIDTH-1){1'b0}}, 1'b1};
        alu_c    = carry_lat;   // C passes through unmasked
        alu_mask = 4'b1010;
      end
      OP_DEC: begin
        alu_res  = a_lat - {{(WIDTH-1){1'b0}}, 1'b1};
        alu_c    = carry_lat;
        alu_mask = 4'b1010;
      end
      OP_AND: begin alu_res = a_lat & b_lat; alu_mask = 4'b1010; end
      OP_OR:  begin alu_res = a_lat | b_lat; alu_mask = 4'b1010; end
      OP_EOR: begin alu_res = a_lat ^ b_lat; alu_mask = 4'b1010; end
      OP_ASL: begin alu_res = {a_lat[MSB-1:0], 1'b0};      alu_c = a_lat[MSB]; alu_mask = 4'b1011; end
      OP_ROL: begin alu_res = {a_lat[MSB-1:0], carry_lat}; alu_c = a_lat[MSB]; alu_mask = 4'b1011; end
      OP_ROR: begin alu_res = {carry_lat, a_lat[MSB:1]};   alu_c = a_lat[0];   alu_mask = 4'b1011; end
      OP_LSR: begin alu_res = {1'b0, a_lat[MSB:1]};        alu_c = a_lat[0];   alu_mask = 4'b1011; end
      default: begin alu_res = a_lat; alu_mask = 4'b0000; end  // undefined op: pass A, nothing written back
    endcase
    if (op_lat == OP_CMP) begin
      alu_n = sum[MSB];
      alu_z = (a_lat == b_lat);
    end else if (op_lat > OP_LSR) begin
      alu_n = 1'b0;
      alu_z = 1'b0;
    end else begin
      alu_n = alu_res[MSB];
      alu_z = (alu_res == {WIDTH{1'b0}});
    end
  end

  // BCD correction; only R and C change, N/V/Z keep their binary values
  always_comb begin
    add_out = bcd_add(a_lat, b_lat, carry_lat);
    if (op_lat == OP_SBC) begin
      adj_res = bcd_sub(a_lat, b_lat, carry_lat);
      adj_c   = flags_q[0];   // no-borrow of the binary subtract
    end else begin
      adj_res = add_out[MSB:0];
      adj_c   = add_out[WIDTH];
    end
  end

  // Working result registers, loaded in EXEC and patched in DADJ
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q   <= {WIDTH{1'b0}};
      flags_q <= 4'b0000;
      mask_q  <= 4'b0000;
    end else begin
      case (state)
        S_EXEC: begin
          res_q   <= alu_res;
          flags_q <= {alu_n, alu_v, alu_z, alu_c};
          mask_q  <= alu_mask;
        end
        S_DADJ: begin
          res_q      <= adj_res;
          flags_q[0] <= adj_c;
        end
        default: ;
      endcase
    end
  end

  // Output registers. The outputs load on the first DONE cycle and then
  // hold until the consumer takes the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_result    <= {WIDTH{1'b0}};
      o_flags     <= 4'b0000;
      o_flag_mask <= 4'b0000;
    end else begin
      o_ready <= (state_nxt == S_IDLE);
      if ((state == S_DONE) && !o_valid) begin
        o_valid     <= 1'b1;
        o_result    <= res_q;
        o_flags     <= flags_q;
        o_flag_mask <= mask_q;
      end else if ((state == S_DONE) && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_m6502_alu_unit.sv
// Bench for m6502_alu_unit. It drives three instances (8-bit with
// decimal mode, 8-bit without decimal mode, 16-bit with decimal mode)
// from one shared stimulus. Each instance is compared against a
// reference model that works with plain integer arithmetic.
module tb_m6502_alu_unit;
  logic        clk = 1'b0;
  logic        reset, i_valid, i_carry, i_decimal, i_ready;
  logic [3:0]  i_op;
  logic [15:0] i_a, i_b;

  logic [7:0]  r8, rn;
  logic [15:0] r16;
  logic [3:0]  f8, fn, f16, m8, mn, m16;
  logic        v8, vn, v16, rdy8, rdyn, rdy16;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  m6502_alu_unit #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut8 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(rdy8), .i_op(i_op),
    .i_a(i_a[7:0]), .i_b(i_b[7:0]), .i_carry(i_carry), .i_decimal(i_decimal),
    .o_valid(v8), .i_ready(i_ready), .o_result(r8), .o_flags(f8), .o_flag_mask(m8));

  m6502_alu_unit #(.WIDTH(8), .DECIMAL_EN(1'b0)) dutn (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(rdyn), .i_op(i_op),
    .i_a(i_a[7:0]), .i_b(i_b[7:0]), .i_carry(i_carry), .i_decimal(i_decimal),
    .o_valid(vn), .i_ready(i_ready), .o_result(rn), .o_flags(fn), .o_flag_mask(mn));

  m6502_alu_unit #(.WIDTH(16), .DECIMAL_EN(1'b1)) dut16 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(rdy16), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_carry(i_carry), .i_decimal(i_decimal),
    .o_valid(v16), .i_ready(i_ready), .o_result(r16), .o_flags(f16), .o_flag_mask(m16));

  typedef struct {
    int lat;
    int r;
    int f;
    int m;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        c, d;
    logic [7:0]  r;
    logic [3:0]  f, m;
    int          lat;
  } tvec_t;

  tvec_t tab[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic straight from the operation rules.
  function automatic exp_t model(input int op, input int a0, input int b0, input int c,
                                 input int d, input int w, input int den);
    exp_t e;
    int mod, msb, a, b, r, cf, vf, zf, nf, m, sa, sb, t, cy, s, bw, dd, rr, dec;
    mod = 1 << w; msb = 1 << (w - 1);
    a = a0 % mod; b = b0 % mod;
    sa = (a >= msb) ? a - mod : a;
    sb = (b >= msb) ? b - mod : b;
    r = 0; cf = 0; vf = 0; m = 0;
    dec = (den != 0 && d != 0 && (op == 0 || op == 3)) ? 1 : 0;
    case (op)
      0: begin t = a + b + c; r = t % mod; cf = (t >= mod); m = 15;
               vf = (sa + sb + c > msb - 1) || (sa + sb + c < -msb); end
      3: begin t = a - b - (1 - c); cf = (t >= 0); r = (t + mod) % mod; m = 15;
               vf = (sa - sb - (1 - c) > msb - 1) || (sa - sb - (1 - c) < -msb); end
      4: begin r = a; cf = (a >= b); m = 11; end
      1: begin r = (a + 1) % mod; cf = c; m = 10; end
      2: begin r = (a + mod - 1) % mod; cf = c; m = 10; end
      5: begin r = a & b; m = 10; end
      6: begin r = a | b; m = 10; end
      7: begin r = a ^ b; m = 10; end
      8: begin r = (a * 2) % mod; cf = (a >= msb); m = 11; end
      9: begin r = (a * 2) % mod + c; cf = (a >= msb); m = 11; end
      10: begin r = a / 2 + c * msb; cf = a % 2; m = 11; end
      11: begin r = a / 2; cf = a % 2; m = 11; end
      default: begin r = a; m = 0; end
    endcase
    zf = (r == 0); nf = (r >= msb);
    if (op == 4) begin zf = (a == b); nf = (((a - b + mod) % mod) >= msb); end
    if (op >= 12) begin zf = 0; nf = 0; end
    if (dec != 0 && op == 0) begin
      cy = c; rr = 0;
      for (int i = 0; i < w / 4; i++) begin
        s = ((a >> (4 * i)) & 15) + ((b >> (4 * i)) & 15) + cy;
        if (s > 9) begin s = s + 6; cy = 1; end else cy = 0;
        rr = rr + ((s % 16) << (4 * i));
      end
      r = rr; cf = cy;
    end
    if (dec != 0 && op == 3) begin
      bw = 1 - c; rr = 0;
      for (int i = 0; i < w / 4; i++) begin
        dd = ((a >> (4 * i)) & 15) - ((b >> (4 * i)) & 15) - bw;
        if (dd < 0) begin dd = dd - 6; bw = 1; end else bw = 0;
        rr = rr + (((dd + 32) % 16) << (4 * i));
      end
      r = rr;
    end
    e.lat = dec ? 3 : 2;
    e.r = r;
    e.f = nf * 8 + vf * 4 + zf * 2 + cf;
    e.m = m;
    return e;
  endfunction

  task automatic chk_dut(input string nm, input int j, input exp_t e, input logic v,
                         input logic rdy, input logic [15:0] r, input logic [3:0] f,
                         input logic [3:0] m);
    chk({nm, "_valid"}, 32'(v), (j == e.lat) ? 32'd1 : 32'd0);
    chk({nm, "_ready"}, 32'(rdy), (j > e.lat) ? 32'd1 : 32'd0);
    if (j == e.lat) begin
      chk({nm, "_result"}, 32'(r), e.r);
      chk({nm, "_flags"}, 32'(f), e.f);
      chk({nm, "_mask"}, 32'(m), e.m);
    end
  endtask

  // Issue one request, scramble the inputs after the accept edge, then
  // follow all three instances through completion with i_ready held high.
  task automatic run_op(input int op, input int a, input int b, input int c, input int d,
                        input bit use_tab, input tvec_t tv);
    exp_t e8, en, e16;
    e8  = model(op, a, b, c, d, 8, 1);
    en  = model(op, a, b, c, d, 8, 0);
    e16 = model(op, a, b, c, d, 16, 1);
    @(negedge clk);
    i_op = 4'(op); i_a = 16'(a); i_b = 16'(b); i_carry = c[0]; i_decimal = d[0];
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_op = 4'($urandom); i_a = 16'($urandom); i_b = 16'($urandom);
    i_carry = 1'($urandom); i_decimal = 1'($urandom);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk_dut("d8", j, e8, v8, rdy8, {8'h00, r8}, f8, m8);
      chk_dut("dn", j, en, vn, rdyn, {8'h00, rn}, fn, mn);
      chk_dut("d16", j, e16, v16, rdy16, r16, f16, m16);
      if (use_tab && j == tv.lat) begin
        chk("tab_valid", 32'(v8), 32'd1);
        chk("tab_result", 32'(r8), 32'(tv.r));
        chk("tab_flags", 32'(f8), 32'(tv.f));
        chk("tab_mask", 32'(m8), 32'(tv.m));
      end
    end
  endtask

  initial begin
    tvec_t none;
    none = '{4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 0};
    //          op     a        b        c     d     r      flags    mask     lat
    tab[0]  = '{4'd0,  16'h50, 16'h50, 1'b0, 1'b0, 8'hA0, 4'b1100, 4'b1111, 2};
    tab[1]  = '{4'd3,  16'h00, 16'h01, 1'b1, 1'b0, 8'hFF, 4'b1000, 4'b1111, 2};
    tab[2]  = '{4'd4,  16'h10, 16'h10, 1'b0, 1'b0, 8'h10, 4'b0011, 4'b1011, 2};
    tab[3]  = '{4'd0,  16'h58, 16'h46, 1'b1, 1'b1, 8'h05, 4'b1101, 4'b1111, 3};
    tab[4]  = '{4'd10, 16'h01, 16'h00, 1'b1, 1'b0, 8'h80, 4'b1001, 4'b1011, 2};
    tab[5]  = '{4'd11, 16'h01, 16'h00, 1'b0, 1'b0, 8'h00, 4'b0011, 4'b1011, 2};
    tab[6]  = '{4'd1,  16'hFF, 16'h00, 1'b1, 1'b0, 8'h00, 4'b0011, 4'b1010, 2};
    tab[7]  = '{4'd2,  16'h00, 16'h00, 1'b0, 1'b0, 8'hFF, 4'b1000, 4'b1010, 2};
    tab[8]  = '{4'd5,  16'hF0, 16'h3C, 1'b0, 1'b0, 8'h30, 4'b0000, 4'b1010, 2};
    tab[9]  = '{4'd7,  16'hFF, 16'hFF, 1'b0, 1'b0, 8'h00, 4'b0010, 4'b1010, 2};
    tab[10] = '{4'd8,  16'h81, 16'h00, 1'b0, 1'b0, 8'h02, 4'b0001, 4'b1011, 2};
    tab[11] = '{4'd13, 16'h85, 16'hFF, 1'b1, 1'b0, 8'h85, 4'b0000, 4'b0000, 2};
    tab[12] = '{4'd3,  16'h10, 16'h01, 1'b1, 1'b1, 8'h09, 4'b0001, 4'b1111, 3};
    tab[13] = '{4'd9,  16'h80, 16'h00, 1'b1, 1'b0, 8'h01, 4'b0001, 4'b1011, 2};
    tab[14] = '{4'd6,  16'h00, 16'h00, 1'b0, 1'b0, 8'h00, 4'b0010, 4'b1010, 2};

    reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_op = 4'd0;
    i_a = 16'd0; i_b = 16'd0; i_carry = 1'b0; i_decimal = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(v8), 32'd0);
    chk("rst_ready", 32'(rdy8), 32'd1);
    chk("rst_result", 32'(r16), 32'd0);
    chk("rst_flags", 32'(f8), 32'd0);
    chk("rst_mask", 32'(m16), 32'd0);
    reset = 1'b0;

    // Directed vectors
    for (int t = 0; t < 15; t++)
      run_op(int'(tab[t].op), int'(tab[t].a), int'(tab[t].b), int'(tab[t].c),
             int'(tab[t].d), 1'b1, tab[t]);

    // Consumer stall: outputs hold, o_ready stays low, extra requests are ignored
    i_ready = 1'b0;
    @(negedge clk);
    i_op = 4'd0; i_a = 16'h0012; i_b = 16'h0034; i_carry = 1'b0; i_decimal = 1'b0;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_first_valid", 32'(v8), 32'd1);
    for (int s = 0; s < 5; s++) begin
      i_valid = 1'b1; i_op = 4'd7; i_a = 16'h00FF; i_b = 16'h000F;
      @(negedge clk);
      chk("stall_valid", 32'(v8), 32'd1);
      chk("stall_ready", 32'(rdy8), 32'd0);
      chk("stall_result", 32'(r8), 32'h46);
      chk("stall_flags", 32'(f8), 32'h0);
      chk("stall_mask", 32'(m8), 32'hF);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(v8), 32'd0);
    chk("release_ready", 32'(rdy8), 32'd1);
    @(negedge clk);
    chk("release_idle_valid", 32'(v16), 32'd0);
    chk("release_idle_ready", 32'(rdy16), 32'd1);

    // Reset while the decimal instance is in its correction cycle
    @(negedge clk);
    i_op = 4'd0; i_a = 16'h0058; i_b = 16'h0046; i_carry = 1'b1; i_decimal = 1'b1;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstdadj_valid", 32'(v8), 32'd0);
    chk("rstdadj_ready", 32'(rdy8), 32'd1);
    chk("rstdadj_result", 32'(r8), 32'd0);
    chk("rstdadj_mask", 32'(m8), 32'd0);
    chk("rstdadj_valid16", 32'(v16), 32'd0);
    @(negedge clk);
    chk("rstdadj_after_valid", 32'(v8), 32'd0);
    chk("rstdadj_after_ready", 32'(rdy8), 32'd1);

    // 16-bit wraparound
    @(negedge clk);
    i_op = 4'd0; i_a = 16'hFFFF; i_b = 16'h0001; i_carry = 1'b0; i_decimal = 1'b0;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("w16_valid", 32'(v16), 32'd1);
    chk("w16_result", 32'(r16), 32'h0000);
    chk("w16_flags", 32'(f16), 32'b0011);
    chk("w16_mask", 32'(m16), 32'b1111);
    repeat (2) @(negedge clk);

    // Random operations against the model
    for (int n = 0; n < 40; n++)
      run_op($urandom_range(15, 0), $urandom_range(65535, 0), $urandom_range(65535, 0),
             $urandom_range(1, 0), $urandom_range(1, 0), 1'b0, none);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
